// File: rtl/bist_sequencer.sv
// bist_sequencer
//
// Top-level scheduler for the BIST engine. It runs the enabled subset of the
// six algorithm selects back-to-back in ascending order: 1 = blanket-0,
// 2 = blanket-0 reversed, 3/4 = checkerboard, 5 = March C, 6 = March A.
// It records the mismatch and timeout result of each algorithm and reports
// one pass/fail verdict through a start/done handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle request, only honoured in IDLE
//   abort        synchronous abort of a running sequence
//   alg_mask     bit i enables select value i+1, captured on accepted start
//   op_done      completion level from the BIST engine
//   err_in       mismatch strobe from the read-compare logic
//   select       registered algorithm select to the engine (0 = none)
//   busy         high from the cycle after an accepted start through DONE
//   done         one-cycle completion pulse
//   pass         1 when no algorithm failed; valid from done onwards
//   fail_map     per-algorithm fail bits (mismatch or timeout)
//   timeout_map  per-algorithm timeout bits
//   aborted      set by abort, cleared by the next accepted start
module bist_sequencer #(
  parameter int SETTLE_CYC  = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 8192,
  parameter int CNT_W       = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] alg_mask,
  input  logic       op_done,
  input  logic       err_in,
  output logic [3:0] select,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_map,
  output logic [5:0] timeout_map,
  output logic       aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [5:0]       pending_q, pending_d;
  logic [2:0]       cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       select_q, select_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [5:0]       fail_q, fail_d;
  logic [5:0]       tmo_q, tmo_d;
  logic             aborted_q, aborted_d;
  logic             err_window;

  // Index of the lowest set bit; the scan runs high to low so the last hit wins.
  function automatic logic [2:0] lowest_idx(input logic [5:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      select_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
      tmo_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      select_q  <= select_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    aborted_d = aborted_q;

    // Mismatches trail the engine pipeline by a cycle, so the first GAP
    // cycle still belongs to the algorithm that just finished.
    err_window = (state_q == S_SETTLE) || (state_q == S_RUN) ||
                 ((state_q == S_GAP) && (cnt_q == '0));

    if (abort && (state_q != S_IDLE)) begin
      // Partial fail/timeout maps are kept for diagnosis; no done pulse.
      state_d   = S_IDLE;
      pending_d = '0;
      busy_d    = 1'b0;
      pass_d    = 1'b0;
      aborted_d = 1'b1;
    end else begin
      if (err_in && err_window) fail_d[cur_q] = 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pending_d = alg_mask;
            fail_d    = '0;
            tmo_d     = '0;
            aborted_d = 1'b0;
            pass_d    = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_LOAD;
          end
        end
        S_LOAD: begin
          if (pending_q == '0) begin
            state_d = S_DONE;
          end else begin
            cur_d   = lowest_idx(pending_q);
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          // op_done may still be stale from the previous algorithm here.
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + CNT_ONE;
          if (op_done) begin
            pending_d[cur_q] = 1'b0;
            cnt_d            = '0;
            state_d          = S_GAP;
          end else if (cnt_q == TMO_LAST) begin
            tmo_d[cur_q]     = 1'b1;
            fail_d[cur_q]    = 1'b1;
            pending_d[cur_q] = 1'b0;
            cnt_d            = '0;
            state_d          = S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so that they are registered
    // and change only on state transitions.
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      pass_d = ~|fail_d;
    end

    if ((state_d == S_SETTLE) || (state_d == S_RUN)) begin
      select_d = {1'b0, cur_d} + 4'd1;
    end else begin
      select_d = 4'd0;
    end
  end

  assign select      = select_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_map    = fail_q;
  assign timeout_map = tmo_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Testbench for bist_sequencer: a behavioural BIST engine answers select with
// op_done after a fixed latency (or never, for a chosen select) and can
// strobe err_in once during a chosen select. Expected verdicts are queued
// when a sequence is started and compared when done pulses.
module tb_bist_sequencer;

  localparam int SETTLE_CYC  = 4;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 8192;
  localparam int CNT_W       = 14;
  localparam int ENG_LAT     = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [5:0] alg_mask;
  logic       op_done;
  logic       err_in;
  logic [3:0] select;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] fail_map;
  logic [5:0] timeout_map;
  logic       aborted;

  always #5 clk = ~clk;

  bist_sequencer #(
    .SETTLE_CYC (SETTLE_CYC),
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .alg_mask   (alg_mask),
    .op_done    (op_done),
    .err_in     (err_in),
    .select     (select),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_map   (fail_map),
    .timeout_map(timeout_map),
    .aborted    (aborted)
  );

  typedef struct {
    logic [5:0] mask;
    logic [3:0] err_sel;
    logic [3:0] hang_sel;
    logic [5:0] exp_fail;
    logic [5:0] exp_tmo;
    logic       exp_pass;
  } vec_t;

  typedef struct {
    logic [5:0]  fail;
    logic [5:0]  tmo;
    logic        pass;
    logic [23:0] seq;
  } exp_t;

  vec_t  vecs[6];
  exp_t  sb_q[$];

  int          total = 0;
  int          bad = 0;
  int          age = 0;
  int          done_cnt = 0;
  logic [3:0]  last_sel = 4'd0;
  logic        have_prev = 1'b0;
  logic [23:0] obs_seq = 24'd0;
  logic        chk_dur = 1'b1;
  logic [3:0]  err_sel = 4'd0;
  logic [3:0]  hang_sel = 4'd0;
  logic        err_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] seq_of(input logic [5:0] m);
    logic [23:0] s;
    s = 24'd0;
    for (int b = 0; b < 6; b++) begin
      if (m[b]) s = {s[19:0], 4'(b + 1)};
    end
    return s;
  endfunction

  // One clock: observe at the falling edge, run the engine model, settle.
  task automatic tick();
    exp_t e;
    int   exp_dur;
    @(negedge clk);
    if (!busy) begin
      have_prev = 1'b0;
      obs_seq   = 24'd0;
    end
    if (select != last_sel) begin
      if (last_sel != 4'd0 && chk_dur) begin
        exp_dur = (last_sel == hang_sel) ? SETTLE_CYC + TIMEOUT_CYC : SETTLE_CYC + ENG_LAT + 1;
        check("sel_len", age, exp_dur);
      end
      if (select != 4'd0) begin
        if (last_sel == 4'd0 && have_prev) check("gap_len", 32'(age >= GAP_CYC), 32'd1);
        obs_seq   = {obs_seq[19:0], select};
        have_prev = 1'b1;
      end
      age      = 0;
      last_sel = select;
    end
    age++;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("fail_map", 32'(fail_map), 32'(e.fail));
        check("timeout_map", 32'(timeout_map), 32'(e.tmo));
        check("pass", 32'(pass), 32'(e.pass));
        check("sel_order", 32'(obs_seq), 32'(e.seq));
      end
      done_cnt++;
    end
    op_done = (select != 4'd0) && (select != hang_sel) && (age >= SETTLE_CYC + ENG_LAT + 1);
    err_in  = err_force | ((select != 4'd0) && (select == err_sel) && (age == SETTLE_CYC + 10));
    #1;
  endtask

  task automatic pulse_start(input logic [5:0] m);
    alg_mask = m;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    alg_mask = 6'($urandom);
  endtask

  task automatic wait_done(input int n0);
    for (int k = 0; k < 20000 && done_cnt == n0; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    check("done_count", done_cnt - n0, 1);
  endtask

  initial begin
    exp_t e;
    int   n0;

    vecs[0] = '{6'b010000, 4'd0, 4'd0, 6'b000000, 6'b000000, 1'b1};
    vecs[1] = '{6'b111111, 4'd0, 4'd0, 6'b000000, 6'b000000, 1'b1};
    vecs[2] = '{6'b100100, 4'd6, 4'd0, 6'b100000, 6'b000000, 1'b0};
    vecs[3] = '{6'b000001, 4'd0, 4'd1, 6'b000001, 6'b000001, 1'b0};
    vecs[4] = '{6'b000000, 4'd0, 4'd0, 6'b000000, 6'b000000, 1'b1};
    vecs[5] = '{6'b000110, 4'd2, 4'd3, 6'b000110, 6'b000100, 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    alg_mask = 6'd0;
    op_done  = 1'b0;
    err_in   = 1'b0;

    #12;
    check("rst_select", 32'(select), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail_map", 32'(fail_map), 32'd0);
    check("rst_timeout_map", 32'(timeout_map), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Table-driven sequences.
    for (int i = 0; i < 6; i++) begin
      err_sel  = vecs[i].err_sel;
      hang_sel = vecs[i].hang_sel;
      e.fail   = vecs[i].exp_fail;
      e.tmo    = vecs[i].exp_tmo;
      e.pass   = vecs[i].exp_pass;
      e.seq    = seq_of(vecs[i].mask);
      sb_q.push_back(e);
      n0 = done_cnt;
      pulse_start(vecs[i].mask);
      check("busy_after_start", 32'(busy), 32'd1);
      wait_done(n0);
      check("busy_after_done", 32'(busy), 32'd0);
      check("pass_held", 32'(pass), 32'(vecs[i].exp_pass));
    end
    err_sel  = 4'd0;
    hang_sel = 4'd0;

    // Empty mask: done exactly two cycles after start; err_in in LOAD/DONE ignored.
    e = '{6'd0, 6'd0, 1'b1, 24'd0};
    sb_q.push_back(e);
    n0 = done_cnt;
    pulse_start(6'b000000);
    check("empty_load_busy", 32'(busy), 32'd1);
    check("empty_load_done", 32'(done), 32'd0);
    err_force = 1'b1;
    err_in    = 1'b1;
    tick();
    check("empty_done_pulse", 32'(done), 32'd1);
    tick();
    err_force = 1'b0;
    err_in    = 1'b0;
    check("empty_idle_busy", 32'(busy), 32'd0);
    check("empty_idle_done", 32'(done), 32'd0);
    check("empty_fail_map", 32'(fail_map), 32'd0);
    check("empty_done_count", done_cnt - n0, 1);

    // Start while busy is ignored: only select 1 runs, single done.
    e = '{6'd0, 6'd0, 1'b1, 24'h000001};
    sb_q.push_back(e);
    n0 = done_cnt;
    pulse_start(6'b000001);
    for (int k = 0; k < 200 && select != 4'd1; k++) tick();
    pulse_start(6'b111111);
    wait_done(n0);

    // Abort during RUN of select 4.
    n0 = done_cnt;
    pulse_start(6'b011000);
    for (int k = 0; k < 500 && !(select == 4'd4 && age >= SETTLE_CYC + 5); k++) tick();
    check("abort_reach_sel4", 32'(select), 32'd4);
    chk_dur = 1'b0;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    check("abort_select", 32'(select), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_flag", 32'(aborted), 32'd1);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_fail_map", 32'(fail_map), 32'd0);
    for (int k = 0; k < 6; k++) tick();
    check("abort_done_count", done_cnt - n0, 0);
    check("abort_held", 32'(aborted), 32'd1);
    chk_dur = 1'b1;
    e = '{6'd0, 6'd0, 1'b1, 24'd0};
    sb_q.push_back(e);
    n0 = done_cnt;
    pulse_start(6'b000000);
    check("abort_cleared", 32'(aborted), 32'd0);
    wait_done(n0);

    // Asynchronous reset in the middle of RUN.
    err_sel  = 4'd1;
    hang_sel = 4'd1;
    chk_dur  = 1'b0;
    pulse_start(6'b000001);
    for (int k = 0; k < 500 && !(select == 4'd1 && age >= SETTLE_CYC + 12); k++) tick();
    check("prerst_select", 32'(select), 32'd1);
    check("prerst_fail_map", 32'(fail_map), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_select", 32'(select), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    check("midrst_fail_map", 32'(fail_map), 32'd0);
    check("midrst_timeout_map", 32'(timeout_map), 32'd0);
    check("midrst_aborted", 32'(aborted), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_select", 32'(select), 32'd0);
    err_sel  = 4'd0;
    hang_sel = 4'd0;
    chk_dur  = 1'b1;

    check("sb_leftover", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
